// File: rtl/axis_video_in_port.sv
// AXI4-Stream video receive port: writes pixels into the write-side FIFO,
// emits frame/line/end alignment strobes and checks line length and frame height.
module axis_video_in_port #(
  parameter int    DSIZE = 24,
  parameter string MODE  = "ONCE"
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [15:0]      vactive,
  input  logic [15:0]      hactive,
  input  logic [DSIZE-1:0] axi_tdata,
  input  logic             axi_tvalid,
  output logic             axi_tready,
  input  logic             axi_tuser,
  input  logic             axi_tlast,
  input  logic             fifo_full,
  input  logic             line_space,
  output logic             wr_en,
  output logic [DSIZE-1:0] wr_data,
  output logic             falign,
  output logic             lalign,
  output logic             ealign,
  output logic             err_early_eol,
  output logic             err_late_eol,
  output logic             err_sof,
  output logic             frame_active
);

  typedef enum logic [1:0] {IDLE, ACTIVE, LINE_WAIT, DISCARD} state_t;

  localparam bit LINE_MODE = (MODE == "LINE");

  state_t           state_q, state_d;
  logic [15:0]      pix_q, pix_d;
  logic [15:0]      line_q, line_d;
  logic             in_frame_q, in_frame_d;
  logic             wr_en_q, wr_en_d;
  logic [DSIZE-1:0] wr_data_q;
  logic             falign_q, falign_d;
  logic             lalign_q, lalign_d;
  logic             ealign_q, ealign_d;
  logic             early_q, early_d;
  logic             late_q, late_d;
  logic             sof_err_q, sof_err_d;
  logic             fa_out_q;

  logic             ready;
  logic             xfer;
  logic             sof;
  logic             write;
  logic             last_pix;
  logic             late;
  logic [15:0]      cur_pix;
  logic [15:0]      cur_line;
  logic [15:0]      hmax;
  logic [15:0]      vmax;

  assign hmax = hactive - 16'd1;
  assign vmax = vactive - 16'd1;

  // Ready is forced low while reset is held so every output reads 0 in reset.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      IDLE:      ready = enable & ~fifo_full & (hactive != 16'd0) & (vactive != 16'd0);
      ACTIVE:    ready = ~fifo_full;
      LINE_WAIT: ready = 1'b0;
      DISCARD:   ready = 1'b1;
      default:   ready = 1'b0;
    endcase
  end

  assign axi_tready = rst_n & ready;
  assign xfer       = axi_tvalid & axi_tready;

  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    line_d     = line_q;
    in_frame_d = in_frame_q;
    wr_en_d    = 1'b0;
    falign_d   = 1'b0;
    lalign_d   = 1'b0;
    ealign_d   = 1'b0;
    early_d    = 1'b0;
    late_d     = 1'b0;
    sof_err_d  = 1'b0;
    sof        = 1'b0;
    write      = 1'b0;
    last_pix   = 1'b0;
    late       = 1'b0;
    cur_pix    = pix_q;
    cur_line   = line_q;

    if (state_q == LINE_WAIT && line_space) begin
      state_d = ACTIVE;
    end

    if (xfer) begin
      case (state_q)
        IDLE, DISCARD: begin
          if (axi_tuser) begin
            sof   = 1'b1;
            write = 1'b1;
          end else if (state_q == DISCARD && axi_tlast) begin
            state_d = in_frame_q ? ACTIVE : IDLE;
          end
        end
        ACTIVE: begin
          write = 1'b1;
          if (axi_tuser) begin
            sof       = 1'b1;
            sof_err_d = (pix_q != 16'd0) || (line_q != 16'd0);
          end
        end
        default: ;
      endcase
    end

    // A start of frame rebases the beat to pixel 0 of line 0 before line-end checks.
    if (sof) begin
      cur_pix    = 16'd0;
      cur_line   = 16'd0;
      falign_d   = 1'b1;
      in_frame_d = 1'b1;
    end

    if (write) begin
      wr_en_d  = 1'b1;
      last_pix = (cur_pix == hmax);
      if (axi_tlast || last_pix) begin
        late     = last_pix & ~axi_tlast;
        lalign_d = 1'b1;
        early_d  = axi_tlast & (cur_pix < hmax);
        late_d   = late;
        pix_d    = 16'd0;
        if (cur_line == vmax) begin
          ealign_d   = 1'b1;
          in_frame_d = 1'b0;
          line_d     = 16'd0;
          state_d    = late ? DISCARD : IDLE;
        end else begin
          line_d  = cur_line + 16'd1;
          state_d = late ? DISCARD : (LINE_MODE ? LINE_WAIT : ACTIVE);
        end
      end else begin
        pix_d   = cur_pix + 16'd1;
        line_d  = cur_line;
        state_d = ACTIVE;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pix_q      <= '0;
      line_q     <= '0;
      in_frame_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      falign_q   <= 1'b0;
      lalign_q   <= 1'b0;
      ealign_q   <= 1'b0;
      early_q    <= 1'b0;
      late_q     <= 1'b0;
      sof_err_q  <= 1'b0;
      fa_out_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      line_q     <= line_d;
      in_frame_q <= in_frame_d;
      wr_en_q    <= wr_en_d;
      if (wr_en_d) wr_data_q <= axi_tdata;
      falign_q   <= falign_d;
      lalign_q   <= lalign_d;
      ealign_q   <= ealign_d;
      early_q    <= early_d;
      late_q     <= late_d;
      sof_err_q  <= sof_err_d;
      // Stays high through the cycle that carries the frame's last write.
      fa_out_q   <= in_frame_d | ealign_d;
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_data       = wr_data_q;
  assign falign        = falign_q;
  assign lalign        = lalign_q;
  assign ealign        = ealign_q;
  assign err_early_eol = early_q;
  assign err_late_eol  = late_q;
  assign err_sof       = sof_err_q;
  assign frame_active  = fa_out_q;

endmodule

// File: tb/tb_axis_video_in_port.sv
// Directed bench for axis_video_in_port: one ONCE-mode and one LINE-mode instance
// on shared inputs, checked cycle by cycle against hand-computed expectations.
module tb_axis_video_in_port;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] vactive = 16'd2;
  logic [15:0] hactive = 16'd4;
  logic [23:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tuser = 1'b0;
  logic        tlast = 1'b0;
  logic        fifo_full = 1'b0;
  logic        line_space = 1'b0;
  logic        sel = 1'b0;

  wire         rdy0, wr0, rdy1, wr1;
  wire [23:0]  dat0, dat1;
  wire [6:0]   flg0, flg1;

  int vectors = 0;
  int miscompares = 0;

  // flag vector bits: falign lalign ealign early late sof frame_active
  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] ACT   = 7'b0000001;
  localparam logic [6:0] FST   = 7'b1000001;
  localparam logic [6:0] LEND  = 7'b0100001;
  localparam logic [6:0] LAST  = 7'b0110001;
  localparam logic [6:0] EARLY = 7'b0101001;
  localparam logic [6:0] LATE  = 7'b0100101;
  localparam logic [6:0] SOFE  = 7'b1000011;
  localparam logic [6:0] ONE   = 7'b1110001;

  always #5 clock = ~clock;

  axis_video_in_port #(.DSIZE(24), .MODE("ONCE")) dut (
    .clock(clock), .rst_n(rst_n), .enable(enable), .vactive(vactive), .hactive(hactive),
    .axi_tdata(tdata), .axi_tvalid(tvalid), .axi_tready(rdy0), .axi_tuser(tuser),
    .axi_tlast(tlast), .fifo_full(fifo_full), .line_space(line_space),
    .wr_en(wr0), .wr_data(dat0), .falign(flg0[6]), .lalign(flg0[5]), .ealign(flg0[4]),
    .err_early_eol(flg0[3]), .err_late_eol(flg0[2]), .err_sof(flg0[1]),
    .frame_active(flg0[0])
  );

  axis_video_in_port #(.DSIZE(24), .MODE("LINE")) dut_line (
    .clock(clock), .rst_n(rst_n), .enable(enable), .vactive(vactive), .hactive(hactive),
    .axi_tdata(tdata), .axi_tvalid(tvalid), .axi_tready(rdy1), .axi_tuser(tuser),
    .axi_tlast(tlast), .fifo_full(fifo_full), .line_space(line_space),
    .wr_en(wr1), .wr_data(dat1), .falign(flg1[6]), .lalign(flg1[5]), .ealign(flg1[4]),
    .err_early_eol(flg1[3]), .err_late_eol(flg1[2]), .err_sof(flg1[1]),
    .frame_active(flg1[0])
  );

  wire        obs_rdy = sel ? rdy1 : rdy0;
  wire        obs_wr  = sel ? wr1 : wr0;
  wire [23:0] obs_dat = sel ? dat1 : dat0;
  wire [6:0]  obs_flg = sel ? flg1 : flg0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive a beat, check ready before the edge, then the registered outputs.
  task automatic step(input string tag, input logic v, input logic [23:0] d, input logic u,
                      input logic l, input logic exp_rdy, input logic exp_wr,
                      input logic [6:0] exp_flg);
    tvalid = v; tdata = d; tuser = u; tlast = l;
    #1;
    chk({tag, ".tready"}, {31'd0, obs_rdy}, {31'd0, exp_rdy});
    @(posedge clock); #1;
    chk({tag, ".wr_en"}, {31'd0, obs_wr}, {31'd0, exp_wr});
    if (exp_wr) chk({tag, ".wr_data"}, {8'd0, obs_dat}, {8'd0, d});
    chk({tag, ".flags"}, {25'd0, obs_flg}, {25'd0, exp_flg});
  endtask

  task automatic do_reset();
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; fifo_full = 1'b0; line_space = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.tready", {31'd0, obs_rdy}, 32'd0);
    chk("rst.wr_en", {31'd0, obs_wr}, 32'd0);
    chk("rst.flags", {25'd0, obs_flg}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic clean_frame(input string tag, input logic [23:0] b);
    step(tag, 1, b + 0, 1, 0, 1, 1, FST);
    step(tag, 1, b + 1, 0, 0, 1, 1, ACT);
    step(tag, 1, b + 2, 0, 0, 1, 1, ACT);
    step(tag, 1, b + 3, 0, 1, 1, 1, LEND);
    step(tag, 1, b + 4, 0, 0, 1, 1, ACT);
    step(tag, 1, b + 5, 0, 0, 1, 1, ACT);
    step(tag, 1, b + 6, 0, 0, 1, 1, ACT);
    step(tag, 1, b + 7, 0, 1, 1, 1, LAST);
    step(tag, 0, 24'h0, 0, 0, 1, 0, NONE);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // enable low and zero geometry block frame start
    enable = 1'b0;
    step("en_off", 1, 24'h0A0, 1, 0, 0, 0, NONE);
    enable = 1'b1;
    hactive = 16'd0;
    step("h_zero", 1, 24'h0B0, 1, 0, 0, 0, NONE);
    hactive = 16'd4;

    clean_frame("basic", 24'h100);

    // fifo_full stall for three cycles inside line 0
    step("stall", 1, 24'h200, 1, 0, 1, 1, FST);
    step("stall", 1, 24'h201, 0, 0, 1, 1, ACT);
    fifo_full = 1'b1;
    step("stall_ff", 1, 24'h202, 0, 0, 0, 0, ACT);
    step("stall_ff", 1, 24'h202, 0, 0, 0, 0, ACT);
    step("stall_ff", 1, 24'h202, 0, 0, 0, 0, ACT);
    fifo_full = 1'b0;
    step("stall", 1, 24'h202, 0, 0, 1, 1, ACT);
    step("stall", 1, 24'h203, 0, 1, 1, 1, LEND);
    step("stall", 1, 24'h204, 0, 0, 1, 1, ACT);
    step("stall", 1, 24'h205, 0, 0, 1, 1, ACT);
    step("stall", 1, 24'h206, 0, 0, 1, 1, ACT);
    step("stall", 1, 24'h207, 0, 1, 1, 1, LAST);
    step("stall", 0, 24'h0, 0, 0, 1, 0, NONE);

    // early end of line on pixel 2
    step("early", 1, 24'h300, 1, 0, 1, 1, FST);
    step("early", 1, 24'h301, 0, 0, 1, 1, ACT);
    step("early_eol", 1, 24'h302, 0, 1, 1, 1, EARLY);
    step("early", 1, 24'h303, 0, 0, 1, 1, ACT);
    step("early", 1, 24'h304, 0, 0, 1, 1, ACT);
    step("early", 1, 24'h305, 0, 0, 1, 1, ACT);
    step("early", 1, 24'h306, 0, 1, 1, 1, LAST);
    step("early", 0, 24'h0, 0, 0, 1, 0, NONE);

    // late end of line: six beats in line 0, beats 4 and 5 dropped
    step("late", 1, 24'h400, 1, 0, 1, 1, FST);
    step("late", 1, 24'h401, 0, 0, 1, 1, ACT);
    step("late", 1, 24'h402, 0, 0, 1, 1, ACT);
    step("late_eol", 1, 24'h403, 0, 0, 1, 1, LATE);
    step("late_drop", 1, 24'h404, 0, 0, 1, 0, ACT);
    step("late_drop", 1, 24'h405, 0, 1, 1, 0, ACT);
    step("late", 1, 24'h406, 0, 0, 1, 1, ACT);
    step("late", 1, 24'h407, 0, 0, 1, 1, ACT);
    step("late", 1, 24'h408, 0, 0, 1, 1, ACT);
    step("late", 1, 24'h409, 0, 1, 1, 1, LAST);
    step("late", 0, 24'h0, 0, 0, 1, 0, NONE);

    // junk before SOF, then tuser on pixel 2 of line 1
    step("junk", 1, 24'h5F0, 0, 0, 1, 0, NONE);
    step("junk", 1, 24'h5F1, 0, 1, 1, 0, NONE);
    step("sof", 1, 24'h500, 1, 0, 1, 1, FST);
    step("sof", 1, 24'h501, 0, 0, 1, 1, ACT);
    step("sof", 1, 24'h502, 0, 0, 1, 1, ACT);
    step("sof", 1, 24'h503, 0, 1, 1, 1, LEND);
    step("sof", 1, 24'h504, 0, 0, 1, 1, ACT);
    step("sof", 1, 24'h505, 0, 0, 1, 1, ACT);
    step("sof_err", 1, 24'h510, 1, 0, 1, 1, SOFE);
    step("sof", 1, 24'h511, 0, 0, 1, 1, ACT);
    step("sof", 1, 24'h512, 0, 0, 1, 1, ACT);
    step("sof", 1, 24'h513, 0, 1, 1, 1, LEND);
    step("sof", 1, 24'h514, 0, 0, 1, 1, ACT);
    step("sof", 1, 24'h515, 0, 0, 1, 1, ACT);
    step("sof", 1, 24'h516, 0, 0, 1, 1, ACT);
    step("sof", 1, 24'h517, 0, 1, 1, 1, LAST);
    step("sof", 0, 24'h0, 0, 0, 1, 0, NONE);

    // one-pixel, one-line frame: SOF beat is also line and frame end
    hactive = 16'd1; vactive = 16'd1;
    step("h1v1", 1, 24'h600, 1, 1, 1, 1, ONE);
    step("h1v1", 0, 24'h0, 0, 0, 1, 0, NONE);
    hactive = 16'd4; vactive = 16'd2;

    // reset in mid-frame, then a clean frame
    step("midrst", 1, 24'h700, 1, 0, 1, 1, FST);
    step("midrst", 1, 24'h701, 0, 0, 1, 1, ACT);
    tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst.tready", {31'd0, obs_rdy}, 32'd0);
    chk("midrst.wr_en", {31'd0, obs_wr}, 32'd0);
    chk("midrst.flags", {25'd0, obs_flg}, 32'd0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    clean_frame("after_rst", 24'h800);

    // LINE mode: hold off after line 0 until line_space
    do_reset();
    sel = 1'b1;
    step("line", 1, 24'h900, 1, 0, 1, 1, FST);
    step("line", 1, 24'h901, 0, 0, 1, 1, ACT);
    step("line", 1, 24'h902, 0, 0, 1, 1, ACT);
    step("line", 1, 24'h903, 0, 1, 1, 1, LEND);
    step("line_wait", 1, 24'h904, 0, 0, 0, 0, ACT);
    step("line_wait", 1, 24'h904, 0, 0, 0, 0, ACT);
    line_space = 1'b1;
    step("line_wait", 1, 24'h904, 0, 0, 0, 0, ACT);
    step("line", 1, 24'h904, 0, 0, 1, 1, ACT);
    step("line", 1, 24'h905, 0, 0, 1, 1, ACT);
    step("line", 1, 24'h906, 0, 0, 1, 1, ACT);
    step("line", 1, 24'h907, 0, 1, 1, 1, LAST);
    step("line", 0, 24'h0, 0, 0, 1, 0, NONE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_video_in_port.md
Name: axis_video_in_port

Overview:
- Receive-side counterpart of the VDMA output port: accepts an AXI4-Stream video stream (tuser = start-of-frame, tlast = end-of-line) and writes pixels into the write-side pixel FIFO.
- Generates frame, line and end alignment strobes for the write-address logic.
- Checks line length and frame height against hactive/vactive, reports violations and resynchronises on the next SOF.

Parameters:
- DSIZE, 24, pixel data width.
- MODE, "ONCE", "ONCE" accepts lines back to back; "LINE" holds tready low after each line until line_space is asserted.

Ports:
- clock  input  1  pixel/stream clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  permits start of a new frame; sampled only in IDLE.
- vactive  input  16  lines per frame.
- hactive  input  16  pixels per line.
- axi_tdata  input  DSIZE  pixel data.
- axi_tvalid  input  1  stream valid.
- axi_tready  output  1  stream ready (combinational from state, enable, fifo_full, line_space).
- axi_tuser  input  1  start of frame, on first pixel.
- axi_tlast  input  1  end of line, on last pixel.
- fifo_full  input  1  FIFO cannot accept a write next cycle.
- line_space  input  1  FIFO can take a full line (LINE mode only).
- wr_en  output  1  FIFO write strobe.
- wr_data  output  DSIZE  FIFO write data.
- falign  output  1  pulse with wr_en of first pixel of frame.
- lalign  output  1  pulse with wr_en of last pixel of each line.
- ealign  output  1  pulse with wr_en of last pixel of last line.
- err_early_eol  output  1  pulse: tlast before pixel hactive-1.
- err_late_eol  output  1  pulse: pixel hactive-1 without tlast.
- err_sof  output  1  pulse: tuser with frame already in progress.
- frame_active  output  1  high from accepted SOF until frame end.

Behaviour:
- Reset: all outputs 0, state IDLE, pix_cnt = 0, line_cnt = 0.
- Transfer: xfer = axi_tvalid & axi_tready.
- Latency: every written beat appears on wr_en/wr_data exactly 1 cycle after xfer. falign, lalign, ealign and the err_* pulses are registered on that same cycle.
- fifo_full is already an almost-full by one; no overflow handling is required here.
- hactive == 0 or vactive == 0: tready held 0 in IDLE; no frame starts.

States:
- IDLE:
  - tready = enable & ~fifo_full.
  - Beat with tuser = 0: discarded, no write.
  - Beat with tuser = 1: written, falign, frame_active <= 1, pix_cnt <= 1, line_cnt <= 0, go to ACTIVE.
  - If hactive == 1: the SOF beat is also the line end (see line end below).
- ACTIVE: tready = ~fifo_full. Each beat is written; pix_cnt increments.
  - Line end occurs when tlast = 1 or pix_cnt == hactive-1.
    - lalign pulses; pix_cnt <= 0; line_cnt increments.
    - tlast early (pix_cnt < hactive-1): err_early_eol pulses.
    - Pixel hactive-1 without tlast: err_late_eol pulses; go to DISCARD.
  - Last line (line_cnt == vactive-1) at line end:
    - ealign also pulses; frame_active <= 0.
    - Next state is IDLE, or DISCARD if the line ended late.
  - Otherwise, MODE "LINE" goes to LINE_WAIT; MODE "ONCE" stays in ACTIVE.
  - tuser = 1 while pix_cnt != 0 or line_cnt != 0:
    - err_sof pulses; the beat is written as the first pixel of a new frame.
    - falign pulses; counters restart (pix_cnt <= 1, line_cnt <= 0).
- LINE_WAIT: tready = 0. Go to ACTIVE when line_space = 1.
- DISCARD:
  - tready = 1; beats are dropped with no wr_en.
  - On a beat with tlast: return to ACTIVE, or to IDLE if the frame ended.
  - On a beat with tuser: handle as SOF in IDLE (written, falign, counters restart).
- Simultaneous tuser & tlast on one beat: SOF handling first, then line-end evaluation.
- enable deasserted mid-frame: the current frame completes; no new SOF is accepted in IDLE.
- Reset mid-frame: immediate return to IDLE; partial frame abandoned; no pulses.
- Counter wrap: not possible, since counters are bounded by hactive-1 / vactive-1 (16 bit).

Test Plan:
- hactive = 4, vactive = 2, ONCE, tvalid constantly 1, correct tuser/tlast -> 8 wr_en.
  - falign with pixel 0; lalign with pixels 3 and 7; ealign with pixel 7.
  - No err_*; frame_active high for 8 cycles.
- Same stream with fifo_full high for 3 cycles mid-line -> tready 0 for exactly those cycles; no beat lost or duplicated; data order preserved.
- hactive = 4, tlast on pixel 2 of line 0 -> err_early_eol and lalign with pixel 2; line 1 starts at the next beat; total writes 7.
- hactive = 4, line 0 carries 6 beats with tlast on the 6th -> err_late_eol with pixel 3; beats 4–5 dropped; line 1 written normally.
- tuser on pixel 2 of line 1 -> err_sof and falign on that beat; counters restart.
  - Junk beats before the first SOF (in IDLE) produce no wr_en.
- MODE = "LINE", line_space low after line 0 -> tready 0 until line_space = 1; the line resumes with no gap in counts.
- Reset asserted mid-frame -> all outputs 0 immediately; the next SOF starts a clean frame.
